// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster-scan timing for a VGA pixel pipeline.
//
// Divides clk down to a pixel-rate enable and sweeps horizontal/vertical
// across the full frame (active + porches + sync), decoding sync, blanking
// and line/frame markers. All outputs are registered.
//
// Optional build macro: VGA_SYNC_DELAY_EN
//   defined   -> hsync/vsync/video_on lag the counters by one pixel, lining
//                them up with a registered pixel generator downstream.
//   undefined -> decodes describe the current counter values.
//
// Ports:
//   clk          in   system clock (only clock)
//   rst_n        in   asynchronous active-low reset
//   horizontal   out  pixel column, 0..H_TOTAL-1
//   vertical     out  line, 0..V_TOTAL-1
//   pix_en       out  one-clk pulse on the first cycle of each pixel
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   video_on     out  high inside the visible region
//   line_start   out  pulse when horizontal becomes 0
//   frame_start  out  pulse when (horizontal, vertical) becomes (0, 0)

module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] horizontal,
    output logic [9:0] vertical,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned CMP_W    = CNT_W + 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Reject parameter sets the 10-bit counters cannot represent.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_check
        $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             pix_en_q, pix_en_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic             tick_c;
    logic [CMP_W-1:0] dec_h_c;
    logic [CMP_W-1:0] dec_v_c;

    // Divider, counters and decodes.
    always_comb begin
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;

        // A tick is the edge on which the divider wraps.
        tick_c = (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);

        if (tick_c) begin
            if (h_q == CNT_W'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end

        pix_en_d      = tick_c;
        line_start_d  = tick_c && (h_d == '0);
        frame_start_d = tick_c && (h_d == '0) && (v_d == '0);

        // Decode either the incoming pixel (zero delay) or the outgoing one.
        // Compared at CMP_W bits so a window ending at 1024 is representable.
`ifdef VGA_SYNC_DELAY_EN
        dec_h_c = {1'b0, h_q};
        dec_v_c = {1'b0, v_q};
`else
        dec_h_c = {1'b0, h_d};
        dec_v_c = {1'b0, v_d};
`endif

        if (tick_c) begin
            hsync_d = ((dec_h_c >= CMP_W'(HS_START)) && (dec_h_c < CMP_W'(HS_END)))
                      ? SYNC_POL : ~SYNC_POL;
            vsync_d = ((dec_v_c >= CMP_W'(VS_START)) && (dec_v_c < CMP_W'(VS_END)))
                      ? SYNC_POL : ~SYNC_POL;
            video_on_d = (dec_h_c < CMP_W'(H_ACTIVE)) && (dec_v_c < CMP_W'(V_ACTIVE));
        end
    end

    // Reset parks the counters on the last pixel so the first tick lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_q           <= CNT_W'(H_TOTAL - 1);
            v_q           <= CNT_W'(V_TOTAL - 1);
            pix_en_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pix_en_q      <= pix_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign horizontal  = h_q;
    assign vertical    = v_q;
    assign pix_en      = pix_en_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// DUT a: default 640x480 timing, CLK_DIV=4, active-low sync.
// DUT b: tiny 16x8 frame, CLK_DIV=1, active-high sync, for full-frame sweeps.

module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, rst_n_b;
    logic [9:0] h_a, v_a, h_b, v_b;
    logic       pe_a, hs_a, vs_a, vo_a, ls_a, fs_a;
    logic       pe_b, hs_b, vs_b, vo_b, ls_b, fs_b;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .horizontal  (h_a),
        .vertical    (v_a),
        .pix_en      (pe_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (vo_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV (1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .horizontal  (h_b),
        .vertical    (v_b),
        .pix_en      (pe_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .video_on    (vo_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) until DUT a shows the given column.
    task automatic wait_h_a(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (h_a == 10'(target)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int   h;
        logic hs;
        logic vs;
        logic vo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit   ok;
        int   h0, npe, last, gap_err;
        logic fs1, pe1, ls1;
        int   p, q, ch, cv, eh, ev;
        int   e_cnt, e_hs, e_vs, e_vo, e_pe, e_ls, e_fs, n_fs, n_ls;
        logic exp_hs, exp_vs, exp_vo;

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;

        // Line-0 decode windows of DUT a: {column, hsync, vsync, video_on}.
`ifdef VGA_SYNC_DELAY_EN
        vecs[0] = '{640, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{641, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{656, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{657, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{752, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{753, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{799, 1'b1, 1'b1, 1'b0};
`else
        vecs[0] = '{639, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{640, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{655, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{656, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{751, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{752, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{799, 1'b1, 1'b1, 1'b0};
`endif

        repeat (3) @(negedge clk);

        // Reset state of DUT a.
        check("rst_h", h_a, 799);
        check("rst_v", v_a, 524);
        check("rst_hsync", hs_a, 1);
        check("rst_vsync", vs_a, 1);
        check("rst_video_on", vo_a, 0);
        check("rst_pix_en", pe_a, 0);
        check("rst_line_start", ls_a, 0);
        check("rst_frame_start", fs_a, 0);

        // First tick lands on the 4th edge after release.
        rst_n_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("pre_tick_h", h_a, 799);
            check("pre_tick_pix_en", pe_a, 0);
            check("pre_tick_hsync", hs_a, 1);
        end
        @(negedge clk);
        check("tick1_h", h_a, 0);
        check("tick1_v", v_a, 0);
        check("tick1_frame_start", fs_a, 1);
        check("tick1_line_start", ls_a, 1);
        check("tick1_pix_en", pe_a, 1);
`ifdef VGA_SYNC_DELAY_EN
        check("tick1_video_on", vo_a, 0);
`else
        check("tick1_video_on", vo_a, 1);
`endif

        // Pixel cadence over 400 clk cycles.
        h0 = int'(h_a);
        npe = 0;
        last = -1;
        gap_err = 0;
        fs1 = 1'b1;
        pe1 = 1'b1;
        ls1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 1) begin
                fs1 = fs_a;
                pe1 = pe_a;
                ls1 = ls_a;
            end
            if (pe_a) begin
                npe++;
                if (last >= 0 && (i - last) != 4) gap_err++;
                last = i;
            end
            @(negedge clk);
        end
        check("pulse_fs_one_cycle", fs1, 0);
        check("pulse_pe_one_cycle", pe1, 0);
        check("pulse_ls_one_cycle", ls1, 0);
        check("cadence_pix_en_count", npe, 100);
        check("cadence_gap_errors", gap_err, 0);
        check("cadence_h_advance", int'(h_a) - h0, 100);

        // Horizontal decode windows on line 0.
        foreach (vecs[k]) begin
            wait_h_a(vecs[k].h, ok);
            check("vec_reached", ok, 1);
            check($sformatf("vec_hsync_h%0d", vecs[k].h), hs_a, vecs[k].hs);
            check($sformatf("vec_vsync_h%0d", vecs[k].h), vs_a, vecs[k].vs);
            check($sformatf("vec_video_on_h%0d", vecs[k].h), vo_a, vecs[k].vo);
        end

        // Line wrap from (799,0).
        check("wrap_pre_v", v_a, 0);
        repeat (4) @(negedge clk);
        check("wrap_h", h_a, 0);
        check("wrap_v", v_a, 1);
        check("wrap_line_start", ls_a, 1);
        check("wrap_frame_start", fs_a, 0);
        check("wrap_pix_en", pe_a, 1);

        // Mid-line reset on DUT a, asserted between edges.
        wait_h_a(300, ok);
        check("mid_a_reached", ok, 1);
        check("mid_a_v", v_a, 1);
        #2 rst_n_a = 1'b0;
        #1;
        check("mid_a_rst_h", h_a, 799);
        check("mid_a_rst_v", v_a, 524);
        check("mid_a_rst_hsync", hs_a, 1);
        check("mid_a_rst_vsync", vs_a, 1);
        check("mid_a_rst_video_on", vo_a, 0);
        check("mid_a_rst_pix_en", pe_a, 0);
        @(negedge clk);
        rst_n_a = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_a_hold_h", h_a, 799);
        @(negedge clk);
        check("mid_a_restart_h", h_a, 0);
        check("mid_a_restart_v", v_a, 0);
        check("mid_a_restart_frame_start", fs_a, 1);

        // DUT b: reset values with active-high sync.
        check("b_rst_hsync", hs_b, 0);
        check("b_rst_vsync", vs_b, 0);
        check("b_rst_h", h_b, 15);
        check("b_rst_v", v_b, 7);

        // DUT b: sweep a little over two frames against a pixel-index model.
        e_cnt = 0; e_hs = 0; e_vs = 0; e_vo = 0; e_pe = 0; e_ls = 0; e_fs = 0;
        n_fs = 0; n_ls = 0;
        rst_n_b = 1'b1;
        for (int k = 1; k <= 272; k++) begin
            @(negedge clk);
            p  = k - 1;
            ch = p % 16;
            cv = (p / 16) % 8;
`ifdef VGA_SYNC_DELAY_EN
            q = (p + 127) % 128;
`else
            q = p % 128;
`endif
            eh = q % 16;
            ev = q / 16;
            exp_hs = (eh >= 10 && eh <= 12);
            exp_vs = (ev >= 5 && ev <= 6);
            exp_vo = (eh < 8 && ev < 4);
            if (h_b != 10'(ch) || v_b != 10'(cv)) e_cnt++;
            if (hs_b !== exp_hs) e_hs++;
            if (vs_b !== exp_vs) e_vs++;
            if (vo_b !== exp_vo) e_vo++;
            if (pe_b !== 1'b1) e_pe++;
            if (ls_b !== (ch == 0)) e_ls++;
            if (fs_b !== (ch == 0 && cv == 0)) e_fs++;
            if (fs_b) n_fs++;
            if (ls_b) n_ls++;
        end
        check("b_counter_errors", e_cnt, 0);
        check("b_hsync_errors", e_hs, 0);
        check("b_vsync_errors", e_vs, 0);
        check("b_video_on_errors", e_vo, 0);
        check("b_pix_en_errors", e_pe, 0);
        check("b_line_start_errors", e_ls, 0);
        check("b_frame_start_errors", e_fs, 0);
        check("b_frame_start_count", n_fs, 3);
        check("b_line_start_count", n_ls, 17);

        // DUT b: mid-frame reset at (4,2).
        repeat (21) @(negedge clk);
        check("mid_b_h", h_b, 4);
        check("mid_b_v", v_b, 2);
        #2 rst_n_b = 1'b0;
        #1;
        check("mid_b_rst_h", h_b, 15);
        check("mid_b_rst_v", v_b, 7);
        check("mid_b_rst_hsync", hs_b, 0);
        check("mid_b_rst_video_on", vo_b, 0);
        check("mid_b_rst_pix_en", pe_b, 0);
        check("mid_b_rst_frame_start", fs_b, 0);
        @(negedge clk);
        rst_n_b = 1'b1;
        @(negedge clk);
        check("mid_b_restart_h", h_b, 0);
        check("mid_b_restart_v", v_b, 0);
        check("mid_b_restart_frame_start", fs_b, 1);
        check("mid_b_restart_pix_en", pe_b, 1);
        check("mid_b_restart_hsync", hs_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Produces the raster scan that drives `Glyph` and the other pixel generators. It divides the system clock down to a pixel-rate enable and sweeps `horizontal`/`vertical` across the full VGA frame, including blanking. From those counters it decodes `hsync`, `vsync`, `video_on` and line/frame markers. It sits between the clock/reset root and the pixel pipeline, and its sync outputs go directly to the VGA connector.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per pixel (100 MHz to 25 MHz); legal range ≥1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: hsync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vsync width.
- `V_BP`, 33: vertical back porch.
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync` (0 = active low).

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `horizontal` out 10: pixel column, 0..H_TOTAL-1.
- `vertical` out 10: line, 0..V_TOTAL-1.
- `pix_en` out 1: one-`clk` pulse marking the first cycle of each pixel.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `video_on` out 1: high while in the visible region.
- `line_start` out 1: pulse when `horizontal` becomes 0.
- `frame_start` out 1: pulse when (`horizontal`,`vertical`) becomes (0,0).

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, default 800.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, default 525.
- Both totals must be ≤1024. A parameter set that violates this is an elaboration error.

Divider:
- Internal counter runs 0..CLK_DIV-1 and wraps.
- A tick occurs on the edge where the divider wraps.
- With CLK_DIV=1, every edge is a tick.

Pixel and line counters:
- On a tick, `horizontal` increments.
- At H_TOTAL-1, `horizontal` wraps to 0 and `vertical` increments.
- At V_TOTAL-1, `vertical` wraps to 0 on the same tick that `horizontal` wraps.

Decodes (all registered; they update on the same edge as the counters and always describe the current counter values):
- `hsync` = SYNC_POL while H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (default 656..751); otherwise ~SYNC_POL.
- `vsync` = SYNC_POL while V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (default 490..491); otherwise ~SYNC_POL.
- `video_on` = (h < H_ACTIVE) && (v < V_ACTIVE).
- `line_start` = `pix_en` && h==0.
- `frame_start` = `pix_en` && h==0 && v==0.

Reset values (applied asynchronously, at any point including mid-frame):
- `horizontal` = H_TOTAL-1, `vertical` = V_TOTAL-1.
- Divider = 0.
- `pix_en`, `line_start`, `frame_start`, `video_on` = 0.
- `hsync`, `vsync` = ~SYNC_POL.

The first tick after reset therefore wraps cleanly to (0,0) and produces `frame_start`. No partial frame is emitted.

## Timing
- First tick: the CLK_DIV-th rising edge after `rst_n` deasserts.
- Ticks repeat every CLK_DIV edges after that.
- `pix_en` is high for exactly one `clk` cycle per pixel, the cycle immediately after the tick edge. The exception is CLK_DIV=1, where `pix_en` is held high.
- Counters and decodes are stable for the whole pixel (CLK_DIV cycles). Downstream logic may sample them on any cycle.
- Latency from counter change to decode change is 0 cycles: both update on the same edge.
- Frame period = H_TOTAL·V_TOTAL·CLK_DIV `clk` cycles; 1,680,000 at defaults.

## Configuration
Macro `VGA_SYNC_DELAY_EN`:
- Defined:
  - `hsync`, `vsync` and `video_on` are delayed by exactly one pixel (one tick). They then reflect the previous pixel's counter values, which aligns them with `Glyph`'s registered `pix`.
  - Counters, `pix_en`, `line_start` and `frame_start` are unchanged.
  - Reset values are as listed in Operation.
- Undefined: zero-delay decode, as in Operation.

## Test plan
1. Reset and first tick (CLK_DIV=4): release `rst_n`. Required: (799,524), `video_on`=0, `hsync`=`vsync`=1 until the 4th edge; then (0,0), `video_on`=1, and `frame_start`, `line_start`, `pix_en` each high for one cycle.
2. Pixel cadence: over 400 `clk` cycles, require `pix_en` high exactly 100 times with 3 low cycles between pulses, and `horizontal` advancing by exactly 100.
3. Line wrap: at h=799 tick, require h→0, v→v+1, one `line_start` pulse, and no `frame_start` when v≠524.
4. Sync windows:
   - `hsync` low exactly for h=656..751 (96 pixels).
   - `vsync` low exactly for v=490..491.
   - `video_on` low for h≥640 or v≥480.
   - Check a full frame: 420,000 ticks with exactly one `frame_start`.
5. Mid-frame reset: assert `rst_n`=0 at (300,200) between edges. Required: outputs take their reset values immediately, without waiting for a clock edge; after release, the frame restarts at (0,0) with `frame_start`.
6. `VGA_SYNC_DELAY_EN` defined: `hsync` falls on the tick where h becomes 657 and rises at h=753; `video_on` falls at h=641; counter sequence is identical to the undefined build.
